hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core. Generates all stall and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards and squashes wrong-path instructions on an EX redirect.
- Sequences the shared multi-cycle mul/div unit: issues start, holds the pipeline until done, and enforces a timeout. The EX stage consumes its stall/flush outputs.

Parameters:
- MD_TIMEOUT, 64, maximum MD_BUSY cycles to wait for md_done before forcing completion (legal range 2..1024)
- PERF_W, 32, width of the performance counters (used only with HAZARD_PERF_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_valid  in  1  EX stage holds a valid instruction
- ex_rd  in  5  EX destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_md_op  in  1  EX instruction is a mul/div
- ex_redirect_valid  in  1  EX branch taken or jump
- md_done  in  1  mul/div unit result ready (1-cycle pulse)
- md_start  out  1  start the mul/div unit
- ex_md_sel  out  1  EX/MEM captures the mul/div result instead of the ALU result
- stall_pc  out  1  hold the PC
- stall_ifid  out  1  hold the IF/ID register
- flush_ifid  out  1  clear the IF/ID register
- stall_idex  out  1  hold the ID/EX register
- flush_idex  out  1  clear the ID/EX register (bubble)
- flush_exmem  out  1  clear the EX/MEM register (bubble)
- md_error  out  1  sticky: a mul/div timeout occurred
- perf_load_use  out  PERF_W  load-use stall count
- perf_md_stall  out  PERF_W  mul/div stall cycle count
- perf_redirect  out  PERF_W  redirect count

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. State resets to IDLE, the timeout counter to 0, md_error to 0 and the perf counters to 0. While rst_n is low, all combinational outputs are forced to 0.
- FSM states: IDLE, MD_BUSY, MD_DONE.
- md_trig = ex_valid & ex_md_op.
- IDLE with md_trig:
  - md_start=1 for this cycle only.
  - stall_pc=stall_ifid=stall_idex=1 and flush_exmem=1.
  - Next state is MD_BUSY.
- MD_BUSY:
  - Same stalls and flush_exmem as above; md_start=0.
  - The timeout counter increments each cycle.
  - md_done=1 -> next state is MD_DONE.
  - Counter reaches MD_TIMEOUT-1 without md_done -> md_error<=1, next state is MD_DONE.
- MD_DONE:
  - ex_md_sel=1 and no mul/div stalls, so ID/EX and EX/MEM advance at this edge.
  - Timeout counter cleared; next state is IDLE.
  - Back-to-back mul/div ops: the next op is seen in IDLE and a new start is issued then.
- md_done outside MD_BUSY is ignored.
- Load-use (evaluated only in IDLE with no md_trig):
  - Condition: id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Response: stall_pc=stall_ifid=1 and flush_idex=1. This is exactly a 1-cycle bubble.
- Redirect:
  - Condition: ex_redirect_valid in IDLE or MD_DONE.
  - Response: flush_ifid=1 and flush_idex=1 in the same cycle.
  - Redirect overrides a load-use stall: stall_pc=stall_ifid=0, so the new PC loads.
- A redirect asserted together with md_trig is a protocol error. md_trig takes priority and the redirect is ignored.
- All stall/flush outputs are combinational from state and inputs; none carry latency beyond that.
- Reset asserted mid mul/div operation: the FSM returns to IDLE immediately and md_start is not re-issued until a fresh md_trig is seen in IDLE.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, three PERF_W-bit saturating counters are implemented:
  - perf_load_use increments on each load-use stall cycle.
  - perf_md_stall increments on each cycle stall_idex is high due to mul/div.
  - perf_redirect increments on each redirect flush.
- When not defined, the counters are absent and the perf_* ports are tied to 0.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle with stall_pc=stall_ifid=flush_idex=1; de-asserted the next cycle once EX advances.
- Load-use with ex_rd=0, or with id_uses_rs1=0 -> no stall or flush.
- Mul/div: md_trig in IDLE, md_done 4 cycles later -> md_start pulses exactly once, stalls held 5 cycles, ex_md_sel=1 for 1 cycle, then IDLE.
- Timeout with MD_TIMEOUT=8 and md_done never asserted -> MD_DONE after 8 MD_BUSY cycles, md_error=1 and stays sticky.
- Redirect concurrent with a load-use condition -> flush_ifid=flush_idex=1, stall_pc=0.
- Reset pulse while in MD_BUSY -> all outputs 0, state IDLE; with HAZARD_PERF_EN, counters read 0 and saturate at 2^PERF_W-1 under a forced preload.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int PERF_W = 32
);
    logic              id_valid;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic              ex_valid;
    logic [4:0]        ex_rd;
    logic              ex_mem_read;
    logic              ex_md_op;
    logic              ex_redirect_valid;
    logic              md_done;

    logic              md_start;
    logic              ex_md_sel;
    logic              stall_pc;
    logic              stall_ifid;
    logic              flush_ifid;
    logic              stall_idex;
    logic              flush_idex;
    logic              flush_exmem;
    logic              md_error;
    logic [PERF_W-1:0] perf_load_use;
    logic [PERF_W-1:0] perf_md_stall;
    logic [PERF_W-1:0] perf_redirect;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_valid, ex_rd, ex_mem_read, ex_md_op, ex_redirect_valid, md_done,
        input  md_start, ex_md_sel, stall_pc, stall_ifid, flush_ifid,
        input  stall_idex, flush_idex, flush_exmem, md_error,
        input  perf_load_use, perf_md_stall, perf_redirect
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_valid, ex_rd, ex_mem_read, ex_md_op, ex_redirect_valid, md_done,
        output md_start, ex_md_sel, stall_pc, stall_ifid, flush_ifid,
        output stall_idex, flush_idex, flush_exmem, md_error,
        output perf_load_use, perf_md_stall, perf_redirect
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage core: load-use bubbles, EX redirects, mul/div hold.
// Optional saturating performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int PERF_W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    localparam int CNT_W = $clog2(MD_TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] to_cnt;
    logic             md_err_q;

    logic md_trig;
    logic md_issue;
    logic md_hold;
    logic src_match;
    logic load_use;
    logic redirect;
    logic lu_stall;

    always_comb begin
        md_trig   = hz.ex_valid & hz.ex_md_op;
        md_issue  = (state == IDLE) & md_trig;
        md_hold   = md_issue | (state == MD_BUSY);
        src_match = (hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                    (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd));
        load_use  = (state == IDLE) & ~md_trig & hz.id_valid & hz.ex_valid &
                    hz.ex_mem_read & (hz.ex_rd != 5'd0) & src_match;
        // A redirect arriving with a new mul/div op is dropped; the op owns EX.
        redirect  = hz.ex_redirect_valid &
                    (((state == IDLE) & ~md_trig) | (state == MD_DONE));
        lu_stall  = load_use & ~redirect;
    end

    assign hz.md_start    = rst_n & md_issue;
    assign hz.ex_md_sel   = rst_n & (state == MD_DONE);
    assign hz.stall_pc    = rst_n & (md_hold | lu_stall);
    assign hz.stall_ifid  = rst_n & (md_hold | lu_stall);
    assign hz.flush_ifid  = rst_n & redirect;
    assign hz.stall_idex  = rst_n & md_hold;
    assign hz.flush_idex  = rst_n & (load_use | redirect);
    assign hz.flush_exmem = rst_n & md_hold;
    assign hz.md_error    = md_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            to_cnt   <= '0;
            md_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_trig) state <= MD_BUSY;
                end
                MD_BUSY: begin
                    to_cnt <= to_cnt + CNT_W'(1);
                    if (hz.md_done) begin
                        state <= MD_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        md_err_q <= 1'b1;
                        state    <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    to_cnt <= '0;
                    state  <= IDLE;
                end
                default: begin
                    to_cnt <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] cnt_lu;
    logic [PERF_W-1:0] cnt_md;
    logic [PERF_W-1:0] cnt_rd;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && (v != {PERF_W{1'b1}})) ? v + PERF_W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_lu <= '0;
            cnt_md <= '0;
            cnt_rd <= '0;
        end else begin
            cnt_lu <= sat_inc(cnt_lu, lu_stall);
            cnt_md <= sat_inc(cnt_md, md_hold);
            cnt_rd <= sat_inc(cnt_rd, redirect);
        end
    end

    assign hz.perf_load_use = cnt_lu;
    assign hz.perf_md_stall = cnt_md;
    assign hz.perf_redirect = cnt_rd;
`else
    assign hz.perf_load_use = '0;
    assign hz.perf_md_stall = '0;
    assign hz.perf_redirect = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazards plus randomized traffic vs a reference model.
`timescale 1ns/1ps
module tb_hazard_ctrl;
    localparam int T  = 8;
    localparam int PW = 32;
    localparam int PH_IDLE = 0;
    localparam int PH_BUSY = 1;
    localparam int PH_DONE = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic err_exp = 1'b0;
    logic [PW-1:0] m_lu = '0;
    logic [PW-1:0] m_md = '0;
    logic [PW-1:0] m_rd = '0;

    hazard_ctrl_if #(.PERF_W(PW)) hz ();

    hazard_ctrl #(.MD_TIMEOUT(T), .PERF_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    // Bit order: md_start, ex_md_sel, stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex, flush_exmem
    function automatic logic [7:0] obs_outs();
        return {hz.md_start, hz.ex_md_sel, hz.stall_pc, hz.stall_ifid,
                hz.flush_ifid, hz.stall_idex, hz.flush_idex, hz.flush_exmem};
    endfunction

    function automatic logic [7:0] exp_outs(input int ph);
        logic trig, lu, rd;
        trig = hz.ex_valid & hz.ex_md_op;
        lu   = hz.id_valid & hz.ex_valid & hz.ex_mem_read & (hz.ex_rd != 5'd0) &
               ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) | (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
        rd   = hz.ex_redirect_valid;
        if (ph == PH_BUSY) return 8'b0011_0101;
        if (ph == PH_DONE) return {1'b0, 1'b1, 1'b0, 1'b0, rd, 1'b0, rd, 1'b0};
        if (trig) return 8'b1011_0101;
        return {2'b00, lu & ~rd, lu & ~rd, rd, 1'b0, lu | rd, 1'b0};
    endfunction

    task automatic model_step(input logic [7:0] e, input int ph);
        if (ph == PH_IDLE && e[5] && !e[2] && m_lu != '1) m_lu = m_lu + 1;
        if (e[2] && m_md != '1) m_md = m_md + 1;
        if (e[3] && m_rd != '1) m_rd = m_rd + 1;
    endtask

    task automatic drive_quiet();
        hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
        hz.ex_valid = 0; hz.ex_rd = 0; hz.ex_mem_read = 0; hz.ex_md_op = 0;
        hz.ex_redirect_valid = 0; hz.md_done = 0;
    endtask

    task automatic drive_noise();
        hz.id_valid    = 1'($urandom_range(0, 1));
        hz.id_rs1      = 5'($urandom_range(0, 3));
        hz.id_rs2      = 5'($urandom_range(0, 3));
        hz.id_uses_rs1 = 1'($urandom_range(0, 1));
        hz.id_uses_rs2 = 1'($urandom_range(0, 1));
        hz.ex_valid    = 1'($urandom_range(0, 1));
        hz.ex_rd       = 5'($urandom_range(0, 3));
        hz.ex_mem_read = 1'($urandom_range(0, 1));
        hz.ex_md_op    = 0;
        hz.ex_redirect_valid = ($urandom_range(0, 3) == 0);
        hz.md_done     = 1'($urandom_range(0, 1));
    endtask

    // One mul/div op; d = cycle of md_done after start (0 or >T means never in time).
    task automatic run_md(input int d, input bit noise, input string tag);
        int b, ph, starts, stalls, sels;
        logic [7:0] e, o;
        b = (d >= 1 && d <= T) ? d : T;
        starts = 0; stalls = 0; sels = 0;
        for (int k = 0; k <= b + 1; k++) begin
            @(negedge clk);
            if (noise) drive_noise(); else drive_quiet();
            hz.ex_valid = 1; hz.ex_md_op = 1;
            ph = (k == 0) ? PH_IDLE : (k <= b) ? PH_BUSY : PH_DONE;
            if (ph == PH_BUSY) hz.md_done = (k == d);
            #1;
            e = exp_outs(ph);
            o = obs_outs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s cycle=%0d outs got=%b exp=%b", tag, k, o, e);
            end
            model_step(e, ph);
            starts += int'(o[7]); stalls += int'(o[2]); sels += int'(o[6]);
            if (ph == PH_DONE) begin
                if (d < 1 || d > T) err_exp = 1'b1;
                n_cmp++;
                if (hz.md_error !== err_exp) begin
                    n_bad++;
                    $display("FAIL %s md_error got=%b exp=%b", tag, hz.md_error, err_exp);
                end
            end
        end
        n_cmp++;
        if (starts != 1 || stalls != b + 1 || sels != 1) begin
            n_bad++;
            $display("FAIL %s_counts starts=%0d stalls=%0d sels=%0d exp 1/%0d/1", tag, starts, stalls, sels, b + 1);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_noise();
            hz.ex_md_op = 1'($urandom_range(0, 1));
            hz.ex_redirect_valid = 1;
            #1;
            n_cmp++;
            if (obs_outs() !== 8'h00 || hz.md_error !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_outs got=%b err=%b exp=00000000 err=0", obs_outs(), hz.md_error);
            end
        end
        n_cmp++;
        if (hz.perf_load_use !== '0 || hz.perf_md_stall !== '0 || hz.perf_redirect !== '0) begin
            n_bad++;
            $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0", hz.perf_load_use, hz.perf_md_stall, hz.perf_redirect);
        end
        @(negedge clk);
        drive_quiet();
        rst_n = 1;
        #1;
        n_cmp++;
        if (obs_outs() !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_release got=%b exp=00000000", obs_outs());
        end
        model_step(8'h00, PH_IDLE);
    endtask

    typedef struct packed {
        logic idv; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
        logic exv; logic [4:0] rd; logic mr; logic rdir; logic [7:0] exp;
    } vec_t;

    task automatic apply_vec(input vec_t v);
        drive_quiet();
        hz.id_valid = v.idv; hz.id_rs1 = v.rs1; hz.id_rs2 = v.rs2;
        hz.id_uses_rs1 = v.u1; hz.id_uses_rs2 = v.u2; hz.ex_valid = v.exv;
        hz.ex_rd = v.rd; hz.ex_mem_read = v.mr; hz.ex_redirect_valid = v.rdir;
    endtask

    task automatic test_load_use();
        vec_t vt [6];
        logic [7:0] e;
        vt[0] = '{1, 5, 0, 1, 0, 1, 5, 1, 0, 8'b0011_0010};
        vt[1] = '{1, 5, 0, 1, 0, 0, 5, 0, 0, 8'b0000_0000};
        vt[2] = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 8'b0000_0000};
        vt[3] = '{1, 5, 0, 0, 0, 1, 5, 1, 0, 8'b0000_0000};
        vt[4] = '{1, 1, 7, 0, 1, 1, 7, 1, 0, 8'b0011_0010};
        vt[5] = '{0, 7, 7, 1, 1, 1, 7, 1, 0, 8'b0000_0000};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            apply_vec(vt[i]);
            #1;
            n_cmp++;
            if (obs_outs() !== vt[i].exp) begin
                n_bad++;
                $display("FAIL load_use_vec%0d got=%b exp=%b", i, obs_outs(), vt[i].exp);
            end
            model_step(vt[i].exp, PH_IDLE);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive_noise();
            #1;
            e = exp_outs(PH_IDLE);
            n_cmp++;
            if (obs_outs() !== e) begin
                n_bad++;
                $display("FAIL load_use_rand i=%0d got=%b exp=%b", i, obs_outs(), e);
            end
            model_step(e, PH_IDLE);
        end
    endtask

    task automatic test_redirect();
        vec_t vt [2];
        vt[0] = '{1, 5, 0, 1, 0, 1, 5, 1, 1, 8'b0000_1010};
        vt[1] = '{0, 0, 0, 0, 0, 1, 3, 0, 1, 8'b0000_1010};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            apply_vec(vt[i]);
            #1;
            n_cmp++;
            if (obs_outs() !== vt[i].exp) begin
                n_bad++;
                $display("FAIL redirect_vec%0d got=%b exp=%b", i, obs_outs(), vt[i].exp);
            end
            model_step(vt[i].exp, PH_IDLE);
        end
        // Redirect together with a new mul/div op: the op wins.
        @(negedge clk);
        drive_quiet();
        hz.ex_valid = 1; hz.ex_md_op = 1; hz.ex_redirect_valid = 1;
        #1;
        n_cmp++;
        if (obs_outs() !== 8'b1011_0101) begin
            n_bad++;
            $display("FAIL redirect_vs_md got=%b exp=10110101", obs_outs());
        end
        model_step(8'b1011_0101, PH_IDLE);
        @(negedge clk);
        hz.ex_redirect_valid = 0; hz.md_done = 1;
        #1;
        n_cmp++;
        if (obs_outs() !== 8'b0011_0101) begin
            n_bad++;
            $display("FAIL redirect_vs_md_busy got=%b exp=00110101", obs_outs());
        end
        model_step(8'b0011_0101, PH_BUSY);
        @(negedge clk);
        hz.md_done = 0; hz.ex_redirect_valid = 1;
        #1;
        n_cmp++;
        if (obs_outs() !== 8'b0100_1010) begin
            n_bad++;
            $display("FAIL redirect_in_done got=%b exp=01001010", obs_outs());
        end
        model_step(8'b0100_1010, PH_DONE);
        @(negedge clk);
        drive_quiet();
        #1;
        n_cmp++;
        if (obs_outs() !== 8'h00) begin
            n_bad++;
            $display("FAIL redirect_back_idle got=%b exp=00000000", obs_outs());
        end
        model_step(8'h00, PH_IDLE);
    endtask

    task automatic test_muldiv();
        run_md(4, 0, "md_d4");
        @(negedge clk);
        drive_quiet();
        #1;
        n_cmp++;
        if (obs_outs() !== 8'h00 || hz.md_error !== 1'b0) begin
            n_bad++;
            $display("FAIL md_idle_after got=%b err=%b exp=00000000 err=0", obs_outs(), hz.md_error);
        end
        model_step(8'h00, PH_IDLE);
        run_md(T, 0, "md_edge_T");
    endtask

    task automatic test_timeout();
        run_md(0, 0, "timeout");
        run_md(3, 0, "sticky");
        repeat (3) begin
            @(negedge clk);
            drive_quiet();
            #1;
            n_cmp++;
            if (hz.md_error !== 1'b1) begin
                n_bad++;
                $display("FAIL md_error_sticky got=%b exp=1", hz.md_error);
            end
            model_step(8'h00, PH_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        run_md(3, 0, "b2b_a");
        run_md(1, 0, "b2b_b");
        for (int i = 0; i < 25; i++) begin
            run_md(int'($urandom_range(0, 11)), 1, "rand_md");
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                drive_noise();
                #1;
                e = exp_outs(PH_IDLE);
                n_cmp++;
                if (obs_outs() !== e) begin
                    n_bad++;
                    $display("FAIL rand_gap i=%0d got=%b exp=%b", i, obs_outs(), e);
                end
                model_step(e, PH_IDLE);
            end
        end
    endtask

    task automatic test_perf();
`ifdef HAZARD_PERF_EN
        n_cmp++;
        if (hz.perf_load_use !== m_lu || hz.perf_md_stall !== m_md || hz.perf_redirect !== m_rd) begin
            n_bad++;
            $display("FAIL perf got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     hz.perf_load_use, hz.perf_md_stall, hz.perf_redirect, m_lu, m_md, m_rd);
        end
`else
        n_cmp++;
        if (hz.perf_load_use !== '0 || hz.perf_md_stall !== '0 || hz.perf_redirect !== '0) begin
            n_bad++;
            $display("FAIL perf_tied got=%0d/%0d/%0d exp=0/0/0", hz.perf_load_use, hz.perf_md_stall, hz.perf_redirect);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_quiet();
            hz.ex_valid = 1; hz.ex_md_op = 1;
            #1;
            e = exp_outs(k == 0 ? PH_IDLE : PH_BUSY);
            n_cmp++;
            if (obs_outs() !== e) begin
                n_bad++;
                $display("FAIL rst_mid_pre k=%0d got=%b exp=%b", k, obs_outs(), e);
            end
            model_step(e, k == 0 ? PH_IDLE : PH_BUSY);
        end
        test_perf();
        @(negedge clk);
        rst_n = 0;
        apply_vec('{1, 5, 0, 1, 0, 1, 5, 1, 1, 8'h00});
        hz.ex_md_op = 1;
        #1;
        err_exp = 1'b0; m_lu = '0; m_md = '0; m_rd = '0;
        n_cmp++;
        if (obs_outs() !== 8'h00 || hz.md_error !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_outs got=%b err=%b exp=00000000 err=0", obs_outs(), hz.md_error);
        end
        test_perf();
        @(negedge clk);
        drive_quiet();
        rst_n = 1;
        repeat (2) begin
            #1;
            n_cmp++;
            if (obs_outs() !== 8'h00) begin
                n_bad++;
                $display("FAIL rst_mid_idle got=%b exp=00000000", obs_outs());
            end
            model_step(8'h00, PH_IDLE);
            @(negedge clk);
        end
        run_md(2, 0, "post_rst");
    endtask

    initial begin
        drive_quiet();
        test_reset();
        test_load_use();
        test_redirect();
        test_muldiv();
        test_timeout();
        test_back_to_back();
        test_perf();
        test_reset_mid();
        test_perf();
        $display("perf model totals: load_use=%0d md_stall=%0d redirect=%0d", m_lu, m_md, m_rd);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
